// File: rtl/i281_datamem_display_pkg.sv
// Shared constants and glyph helper for the i281 data-memory display.
// The display has four digits and shows eight-bit data-memory words.
package i281_datamem_display_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int WORD_W     = 8;
    localparam int NUM_WORDS  = 16;
    localparam int BUS_W      = NUM_WORDS * WORD_W;

    localparam logic [6:0] SEG_ZERO = 7'b1000000;
    localparam logic [3:0] AN_RESET = 4'b1110;

    // Digit slots, listed from the rightmost digit to the leftmost.
    typedef enum logic [1:0] {
        DIG_VAL_LO = 2'd0,
        DIG_VAL_HI = 2'd1,
        DIG_ADDR   = 2'd2,
        DIG_ZERO   = 2'd3
    } digit_e;

    // Active-low segments: bit0 = a ... bit6 = g; b and d are lower case.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/i281_datamem_display_debounce.sv
// Button synchronizer and debouncer that emits a single-cycle pulse on each accepted press.
// A button that is already down when reset is released stays silent until it has been released once.
module i281_debounce
    import i281_datamem_display_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [1:0]       r_vld;
    logic             r_armed;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    logic w_tc;
    logic w_accept;

    assign w_tc     = (r_cnt == '0);
    assign w_accept = (r_sync2 != r_level) && w_tc;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_vld   <= 2'b00;
            r_armed <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= CNT_LOAD;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            r_vld   <= {r_vld[0], 1'b1};
            // r_vld[1] marks the first r_sync2 value that came from the pin rather than from reset.
            if (r_vld[1] && !r_sync2)
                r_armed <= 1'b1;
            if (r_sync2 == r_level) begin
                r_cnt <= CNT_LOAD;
            end else if (w_tc) begin
                r_level <= r_sync2;
                r_cnt   <= CNT_LOAD;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign level       = r_level;
    assign press_pulse = w_accept && r_sync2 && r_armed;

endmodule

// File: rtl/i281_datamem_display.sv
// Shows one selected data-memory word (address and value) on a multiplexed 4-digit display.
// Also provides a snapshot hold and a sticky flag that reports a change of the live word.
module i281_datamem_display
    import i281_datamem_display_pkg::*;
#(
    parameter int CLK_DIV         = 50000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [BUS_W-1:0] datamem_bus,
    input  logic             btn_next,
    input  logic             btn_prev,
    input  logic             hold,
    output logic [6:0]       seg,
    output logic [3:0]       an,
    output logic [3:0]       sel_addr,
    output logic             changed
);

    localparam int PRE_W = $clog2(CLK_DIV);
    localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(CLK_DIV - 1);

    logic [3:0]        r_sel;
    logic              r_sel_chg;
    logic [WORD_W-1:0] r_value_q;
    logic [WORD_W-1:0] r_baseline_q;
    logic              r_changed;
    logic [PRE_W-1:0]  r_presc;
    digit_e            r_digit;
    logic [6:0]        r_seg;
    logic [3:0]        r_an;

    logic              w_next_pulse;
    logic              w_prev_pulse;
    logic              w_next_level;
    logic              w_prev_level;
    logic [1:0]        w_unused_levels;
    logic              w_step_next;
    logic              w_step_prev;
    logic              w_sel_move;
    logic [WORD_W-1:0] w_word;
    logic [3:0]        w_nibble;

    i281_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clock      (clock),
        .reset      (reset),
        .raw        (btn_next),
        .level      (w_next_level),
        .press_pulse(w_next_pulse)
    );

    i281_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
        .clock      (clock),
        .reset      (reset),
        .raw        (btn_prev),
        .level      (w_prev_level),
        .press_pulse(w_prev_pulse)
    );

    assign w_unused_levels = {w_next_level, w_prev_level};

    assign w_step_next = w_next_pulse && !w_prev_pulse;
    assign w_step_prev = w_prev_pulse && !w_next_pulse;
    assign w_sel_move  = w_step_next || w_step_prev;
    assign w_word      = datamem_bus[{r_sel, 3'b000} +: WORD_W];

    always_comb begin
        w_nibble = 4'h0;
        case (r_digit)
            DIG_VAL_LO: w_nibble = r_value_q[3:0];
            DIG_VAL_HI: w_nibble = r_value_q[7:4];
            DIG_ADDR:   w_nibble = r_sel;
            default:    w_nibble = 4'h0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sel        <= 4'd0;
            r_sel_chg    <= 1'b0;
            r_value_q    <= '0;
            r_baseline_q <= '0;
            r_changed    <= 1'b0;
        end else begin
            if (w_step_next)
                r_sel <= r_sel + 4'd1;
            else if (w_step_prev)
                r_sel <= r_sel - 4'd1;
            r_sel_chg <= w_sel_move;

            // The first cycle on a new address re-baselines even while the display is held.
            if (r_sel_chg) begin
                r_value_q    <= w_word;
                r_baseline_q <= w_word;
            end else if (!hold) begin
                r_value_q <= w_word;
            end

            // The baseline is stale until r_sel_chg has loaded it, so comparisons wait a cycle.
            if (w_sel_move || r_sel_chg)
                r_changed <= 1'b0;
            else if (w_word != r_baseline_q)
                r_changed <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_presc <= '0;
            r_digit <= DIG_VAL_LO;
            r_seg   <= SEG_ZERO;
            r_an    <= AN_RESET;
        end else begin
            if (r_presc == PRE_TC) begin
                r_presc <= '0;
                r_digit <= digit_e'(r_digit + 2'd1);
            end else begin
                r_presc <= r_presc + 1'b1;
            end
            r_seg <= hex_to_seg(w_nibble);
            r_an  <= ~(4'b0001 << r_digit);
        end
    end

    assign seg      = r_seg;
    assign an       = r_an;
    assign sel_addr = r_sel;
    assign changed  = r_changed;

endmodule

// File: tb/tb_i281_datamem_display.sv
// Directed bench for the data-memory display: refresh, debounce, selection, hold/changed and reset.
module tb_i281_datamem_display;

    logic         clock = 1'b0;
    logic         reset;
    logic [127:0] datamem_bus;
    logic         btn_next;
    logic         btn_prev;
    logic         hold;
    logic [6:0]   seg;
    logic [3:0]   an;
    logic [3:0]   sel_addr;
    logic         changed;

    int checks = 0;
    int errors = 0;
    int found;

    localparam logic [6:0] G_0 = 7'b1000000;
    localparam logic [6:0] G_3 = 7'b0110000;
    localparam logic [6:0] G_C = 7'b1000110;

    i281_datamem_display #(.CLK_DIV(4), .DEBOUNCE_CYCLES(3)) dut (
        .clock      (clock),
        .reset      (reset),
        .datamem_bus(datamem_bus),
        .btn_next   (btn_next),
        .btn_prev   (btn_prev),
        .hold       (hold),
        .seg        (seg),
        .an         (an),
        .sel_addr   (sel_addr),
        .changed    (changed)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int k, input logic [7:0] v);
        datamem_bus[k*8 +: 8] = v;
    endtask

    task automatic press(input logic n, input logic p);
        btn_next = n;
        btn_prev = p;
        step(6);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        step(7);
    endtask

    initial begin
        reset       = 1'b1;
        datamem_bus = '0;
        btn_next    = 1'b0;
        btn_prev    = 1'b0;
        hold        = 1'b0;
        set_word(0, 8'h3C);
        step(2);
        chk("rst_an", 32'(an), 32'(4'b1110));
        chk("rst_seg", 32'(seg), 32'(G_0));
        chk("rst_sel", 32'(sel_addr), 32'd0);
        chk("rst_changed", 32'(changed), 32'd0);
        reset = 1'b0;

        step(1);
        chk("ref_p1_an", 32'(an), 32'(4'b1110));
        chk("ref_p1_seg", 32'(seg), 32'(G_0));
        step(1);
        chk("ref_p2_seg_C", 32'(seg), 32'(G_C));
        step(2);
        chk("ref_p4_an", 32'(an), 32'(4'b1110));
        step(1);
        chk("ref_d1_an", 32'(an), 32'(4'b1101));
        chk("ref_d1_seg_3", 32'(seg), 32'(G_3));
        step(4);
        chk("ref_d2_an", 32'(an), 32'(4'b1011));
        chk("ref_d2_seg", 32'(seg), 32'(G_0));
        step(4);
        chk("ref_d3_an", 32'(an), 32'(4'b0111));
        chk("ref_d3_seg", 32'(seg), 32'(G_0));
        step(3);
        chk("ref_d3_end_an", 32'(an), 32'(4'b0111));
        step(1);
        chk("ref_wrap_an", 32'(an), 32'(4'b1110));
        chk("ref_wrap_seg", 32'(seg), 32'(G_C));

        btn_next = 1'b1;
        step(2);
        btn_next = 1'b0;
        step(8);
        chk("glitch_sel", 32'(sel_addr), 32'd0);

        btn_next = 1'b1;
        step(4);
        chk("db_early_sel", 32'(sel_addr), 32'd0);
        step(1);
        chk("db_edge_sel", 32'(sel_addr), 32'd1);
        step(5);
        chk("db_once_sel", 32'(sel_addr), 32'd1);
        btn_next = 1'b0;
        step(8);

        press(1'b0, 1'b1);
        chk("prev_1_to_0", 32'(sel_addr), 32'd0);
        press(1'b0, 1'b1);
        chk("prev_wrap", 32'(sel_addr), 32'd15);
        press(1'b1, 1'b0);
        chk("next_wrap", 32'(sel_addr), 32'd0);
        press(1'b1, 1'b1);
        chk("both_nochange", 32'(sel_addr), 32'd0);

        set_word(5, 8'h11);
        hold = 1'b1;
        repeat (5) press(1'b1, 1'b0);
        chk("sel5", 32'(sel_addr), 32'd5);
        chk("sel5_value", 32'(dut.r_value_q), 32'h11);
        chk("sel5_changed", 32'(changed), 32'd0);
        set_word(5, 8'h22);
        step(1);
        chk("hold_value", 32'(dut.r_value_q), 32'h11);
        chk("hold_changed", 32'(changed), 32'd1);
        hold = 1'b0;
        step(1);
        chk("unhold_value", 32'(dut.r_value_q), 32'h22);
        chk("unhold_changed", 32'(changed), 32'd1);

        hold = 1'b1;
        set_word(6, 8'h5A);
        btn_next = 1'b1;
        step(5);
        chk("sel6", 32'(sel_addr), 32'd6);
        chk("sel6_changed_clr", 32'(changed), 32'd0);
        chk("sel6_value_old", 32'(dut.r_value_q), 32'h22);
        step(1);
        chk("sel6_value_new", 32'(dut.r_value_q), 32'h5A);
        chk("sel6_changed", 32'(changed), 32'd0);
        btn_next = 1'b0;
        step(7);

        btn_next = 1'b1;
        step(6);
        chk("sel7", 32'(sel_addr), 32'd7);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (dut.r_digit == 2'd2) found = 1;
            else step(1);
        end
        chk("digit2_reached", 32'(found), 32'd1);
        reset = 1'b1;
        step(1);
        chk("mid_rst_an", 32'(an), 32'(4'b1110));
        chk("mid_rst_seg", 32'(seg), 32'(G_0));
        chk("mid_rst_sel", 32'(sel_addr), 32'd0);
        chk("mid_rst_changed", 32'(changed), 32'd0);
        chk("mid_rst_value", 32'(dut.r_value_q), 32'd0);
        reset = 1'b0;
        step(15);
        chk("held_thru_rst", 32'(sel_addr), 32'd0);
        btn_next = 1'b0;
        step(8);
        chk("release_no_press", 32'(sel_addr), 32'd0);
        press(1'b1, 1'b0);
        chk("repress_sel", 32'(sel_addr), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
